multi_ff_bank: RTL and testbench

MULTI_FF_BANK -- requirements
Module: multi_ff_bank

---
 rtl/multi_ff_pkg.sv | 24 ++
 rtl/ff_cell_next.sv | 42 ++++
 rtl/multi_ff_bank.sv | 100 ++++++++++
 tb/tb_multi_ff_bank.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/multi_ff_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multi_ff_pkg                                                  |
// | Purpose  : Shared mode encodings and default parameter constants for the |
// |            multi_ff_bank flip-flop bank.                                 |
// | Contents : mode_t       - 2-bit per-bank flop behaviour selector         |
// |            DEF_WIDTH    - default channel count                         |
// |            DEF_ERR_CNT_W- default illegal-event counter width           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package multi_ff_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_SR = 2'b01,
    MODE_JK = 2'b10,
    MODE_T  = 2'b11
  } mode_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ERR_CNT_W = 8;

endpackage : multi_ff_pkg
`default_nettype wire

// File: rtl/ff_cell_next.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ff_cell_next                                                  |
// | Purpose  : Combinational next-state function of one configurable flop.  |
// | Ports    : mode_i  - flop behaviour (D / SR / JK / T)                    |
// |            a_i     - primary input  (D / S / J / T)                      |
// |            b_i     - secondary input (R / K, unused for D and T)         |
// |            q_i     - current flop state                                 |
// |            d_o     - next flop state                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ff_cell_next
  import multi_ff_pkg::*;
(
  input  mode_t mode_i,
  input  logic  a_i,
  input  logic  b_i,
  input  logic  q_i,
  output logic  d_o
);

  always_comb begin
    d_o = q_i;
    case (mode_i)
      MODE_D:  d_o = a_i;
      // Set-dominant: S=R=1 forces the flop high.
      MODE_SR: d_o = a_i | (~b_i & q_i);
      MODE_JK: begin
        case ({a_i, b_i})
          2'b00:   d_o = q_i;
          2'b10:   d_o = 1'b1;
          2'b01:   d_o = 1'b0;
          default: d_o = ~q_i;
        endcase
      end
      MODE_T:  d_o = q_i ^ a_i;
      default: d_o = q_i;
    endcase
  end

endmodule : ff_cell_next
`default_nettype wire

// File: rtl/multi_ff_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multi_ff_bank                                                 |
// | Purpose  : WIDTH independent flops sharing one mode (D/SR/JK/T), with    |
// |            detection, latching and counting of SR S=R=1 events.          |
// | Ports    : clk        - rising-edge clock                               |
// |            rst_n      - asynchronous active-low reset                    |
// |            en         - update enable (0 = hold)                         |
// |            mode       - flop behaviour for the whole bank                |
// |            a, b       - per-channel primary / secondary inputs           |
// |            clr_err    - synchronous clear of err_sticky and err_cnt      |
// |            q, qbar    - channel state and its complement                 |
// |            illegal    - one-cycle pulse after an SR S=R=1 edge           |
// |            err_sticky - latched illegal indication                       |
// |            err_cnt    - saturating illegal-edge counter                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module multi_ff_bank
  import multi_ff_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qbar,
  output logic                 illegal,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0]     q_q, q_d, cell_d;
  logic                 illegal_q;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 illegal_cond;
  mode_t                mode_e;

  assign mode_e = mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell_next u_cell (
      .mode_i (mode_e),
      .a_i    (a[i]),
      .b_i    (b[i]),
      .q_i    (q_q[i]),
      .d_o    (cell_d[i])
    );
  end

  assign q_d          = en ? cell_d : q_q;
  // Any number of colliding bits in one edge is a single event.
  assign illegal_cond = en & (mode_e == MODE_SR) & (|(a & b));

  always_comb begin
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (illegal_cond) begin
      // A fresh event overrides a simultaneous clear.
      err_sticky_d = 1'b1;
      if (clr_err) begin
        err_cnt_d = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end else if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q          <= RESET_VAL;
      illegal_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      q_q          <= q_d;
      illegal_q    <= illegal_cond;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign q          = q_q;
  assign qbar       = ~q_q;
  assign illegal    = illegal_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

endmodule : multi_ff_bank
`default_nettype wire

// File: tb/tb_multi_ff_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_multi_ff_bank                                              |
// | Purpose  : Directed self-checking bench for multi_ff_bank (WIDTH=8,      |
// |            RESET_VAL=8'hA5, ERR_CNT_W=8).                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_multi_ff_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       clr_err = 1'b0;
  logic [7:0] q, qbar;
  logic       illegal, err_sticky;
  logic [7:0] err_cnt;

  int passed = 0;
  int total  = 0;

  multi_ff_bank #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5),
    .ERR_CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .a          (a),
    .b          (b),
    .clr_err    (clr_err),
    .q          (q),
    .qbar       (qbar),
    .illegal    (illegal),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] va,
                       input logic [7:0] vb, input logic c);
    en = e; mode = m; a = va; b = vb; clr_err = c;
  endtask

  initial begin
    int exp_cnt;

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_q",      q,          64'hA5);
    check("rst_qbar",   qbar,       64'h5A);
    check("rst_cnt",    err_cnt,    64'h0);
    check("rst_ill",    illegal,    64'h0);
    check("rst_sticky", err_sticky, 64'h0);
    #1 rst_n = 1'b1;

    // D mode load of zero
    drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
    step();
    check("d_q0", q, 64'h00);

    // SR set/reset without collision
    drive(1'b1, 2'b01, 8'h0F, 8'hF0, 1'b0);
    step();
    check("sr_q",   q,       64'h0F);
    check("sr_ill", illegal, 64'h0);

    // SR S=R=1 on bit 0: set-dominant, one illegal event
    drive(1'b1, 2'b01, 8'h01, 8'h01, 1'b0);
    step();
    check("srx_q",      q,          64'h0F);
    check("srx_ill",    illegal,    64'h1);
    check("srx_sticky", err_sticky, 64'h1);
    check("srx_cnt",    err_cnt,    64'h1);

    // JK toggle twice; illegal pulse must have dropped
    drive(1'b1, 2'b10, 8'hFF, 8'hFF, 1'b0);
    step();
    check("jk1_q",      q,          64'hF0);
    check("jk1_qbar",   qbar,       64'h0F);
    check("jk1_ill",    illegal,    64'h0);
    check("jk1_sticky", err_sticky, 64'h1);
    step();
    check("jk2_q",   q,       64'h0F);
    check("jk2_ill", illegal, 64'h0);
    check("jk2_cnt", err_cnt, 64'h1);

    // JK set/reset/hold mix: J=F0,K=0C on q=0F -> set hi nibble, reset bits 3:2
    drive(1'b1, 2'b10, 8'hF0, 8'h0C, 1'b0);
    step();
    check("jk3_q", q, 64'hF3);

    // en=0 holds q even with SR collision inputs; no event counted
    drive(1'b0, 2'b01, 8'h55, 8'h55, 1'b0);
    step();
    check("hold_q",   q,       64'hF3);
    check("hold_ill", illegal, 64'h0);
    check("hold_cnt", err_cnt, 64'h1);

    // T mode: bit 0 alternates
    drive(1'b1, 2'b11, 8'h01, 8'hFF, 1'b0);
    step();
    check("t1_q", q, 64'hF2);
    step();
    check("t2_q", q, 64'hF3);
    step();
    check("t3_q", q, 64'hF2);

    // clr_err alone, with en=0
    drive(1'b0, 2'b11, 8'h01, 8'h00, 1'b1);
    step();
    check("clr_sticky", err_sticky, 64'h0);
    check("clr_cnt",    err_cnt,    64'h0);
    check("clr_q",      q,          64'hF2);

    // clr_err with a simultaneous illegal event: event wins
    drive(1'b1, 2'b01, 8'h01, 8'h01, 1'b1);
    step();
    check("clrx_sticky", err_sticky, 64'h1);
    check("clrx_cnt",    err_cnt,    64'h1);
    check("clrx_q",      q,          64'hF3);

    // Saturation: 300 more illegal edges, multi-bit collisions count once
    drive(1'b1, 2'b01, 8'hC0, 8'hC0, 1'b0);
    exp_cnt = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (i == 0 || i == 253 || i == 254 || i == 255 || i == 299)
        check($sformatf("sat_cnt_%0d", i), err_cnt, 64'(exp_cnt));
    end
    check("sat_final", err_cnt, 64'd255);
    check("sat_q",     q,       64'hF3);

    // Leave SR: pulse ends, counter holds
    drive(1'b1, 2'b00, 8'h3C, 8'hFF, 1'b0);
    step();
    check("d2_q",   q,       64'h3C);
    check("d2_ill", illegal, 64'h0);
    check("d2_cnt", err_cnt, 64'd255);

    // Reset mid-stream during an illegal pulse
    drive(1'b1, 2'b01, 8'h01, 8'h01, 1'b0);
    step();
    check("pre_rst_ill", illegal, 64'h1);
    rst_n = 1'b0;
    #1;
    check("mrst_q",      q,          64'hA5);
    check("mrst_qbar",   qbar,       64'h5A);
    check("mrst_ill",    illegal,    64'h0);
    check("mrst_cnt",    err_cnt,    64'h0);
    check("mrst_sticky", err_sticky, 64'h0);
    #1 rst_n = 1'b1;
    drive(1'b1, 2'b00, 8'h12, 8'h00, 1'b0);
    step();
    check("post_rst_q",   q,       64'h12);
    check("post_rst_ill", illegal, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_multi_ff_bank
`default_nettype wire
